// File: rtl/key_loader_pkg.sv
// Shared definitions for the serial key loader that feeds a locked core's key port.
// Holds default widths, the loader state encoding and the parity sense.
package key_loader_pkg;

    localparam int   KEY_W_DEF    = 8;
    localparam int   MAX_FAIL_DEF = 3;
    localparam logic PARITY_EVEN  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_CHECK   = 2'd2,
        ST_LOCKOUT = 2'd3
    } key_ld_state_t;

endpackage : key_loader_pkg

// File: rtl/key_loader.sv
// Serial key loader: shifts in an LSB-first key plus even parity and commits it
// to the locked core only on a parity pass; repeated failures latch a tamper lockout.
module key_loader
    import key_loader_pkg::*;
#(
    parameter int KEY_W    = KEY_W_DEF,
    parameter int MAX_FAIL = MAX_FAIL_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load_start,
    input  logic             i_key_bit,
    input  logic             i_key_bit_vld,
    output logic [KEY_W-1:0] o_key,
    output logic             o_key_valid,
    output logic             o_load_busy,
    output logic             o_load_err,
    output logic             o_lockout
);

    localparam int CNT_W  = $clog2(KEY_W + 1);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);

    key_ld_state_t     r_state;
    key_ld_state_t     w_next_state;
    logic [KEY_W-1:0]  r_shreg;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_pbit;
    logic [FAIL_W-1:0] r_fail_cnt;
    logic [KEY_W-1:0]  r_key;
    logic              r_key_valid;
    logic              r_load_err;
    logic              r_lockout;
    logic              w_pass;
    logic              w_last_fail;
    logic              w_cnt_full;

    // Next-state decode and parity verdict for the CHECK cycle
    always_comb begin
        w_next_state = r_state;
        w_pass       = ((^r_shreg) ^ r_pbit) == PARITY_EVEN;
        w_last_fail  = (r_fail_cnt >= FAIL_W'(MAX_FAIL - 1));
        w_cnt_full   = (r_cnt == CNT_W'(KEY_W));
        case (r_state)
            ST_IDLE: begin
                if (i_load_start) begin
                    w_next_state = ST_SHIFT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (i_key_bit_vld && w_cnt_full) begin
                    w_next_state = ST_CHECK;
                end else begin
                    w_next_state = ST_SHIFT;
                end
            end
            ST_CHECK: begin
                if (w_pass) begin
                    w_next_state = ST_IDLE;
                end else if (w_last_fail) begin
                    w_next_state = ST_LOCKOUT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                w_next_state = ST_LOCKOUT;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register, shift register, bit/fail counters and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_pbit      <= 1'b0;
            r_fail_cnt  <= '0;
            r_key       <= '0;
            r_key_valid <= 1'b0;
            r_load_err  <= 1'b0;
            r_lockout   <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_load_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Drop the old key the moment a new load begins
                    if (i_load_start) begin
                        r_cnt       <= '0;
                        r_shreg     <= '0;
                        r_key       <= '0;
                        r_key_valid <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (i_key_bit_vld) begin
                        if (w_cnt_full) begin
                            r_pbit <= i_key_bit;
                        end else begin
                            // LSB arrives first, so it ends up at bit 0 after KEY_W shifts
                            r_shreg <= {i_key_bit, r_shreg[KEY_W-1:1]};
                            r_cnt   <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    if (w_pass) begin
                        r_key       <= r_shreg;
                        r_key_valid <= 1'b1;
                        r_fail_cnt  <= '0;
                    end else begin
                        r_load_err <= 1'b1;
                        if (r_fail_cnt != FAIL_W'(MAX_FAIL)) begin
                            r_fail_cnt <= r_fail_cnt + FAIL_W'(1);
                        end
                        if (w_last_fail) begin
                            r_lockout   <= 1'b1;
                            r_key       <= '0;
                            r_key_valid <= 1'b0;
                        end
                    end
                end
                ST_LOCKOUT: begin
                    r_lockout   <= 1'b1;
                    r_key       <= '0;
                    r_key_valid <= 1'b0;
                end
                default: begin
                    r_key       <= '0;
                    r_key_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_key       = r_key;
    assign o_key_valid = r_key_valid;
    assign o_load_err  = r_load_err;
    assign o_lockout   = r_lockout;
    assign o_load_busy = (r_state == ST_SHIFT) || (r_state == ST_CHECK);

endmodule : key_loader

// File: tb/tb_key_loader.sv
// Directed self-checking bench for key_loader: inputs driven and outputs
// sampled on the falling edge, expected values hand-computed per scenario.
module tb_key_loader;

    logic       clk;
    logic       i_rst;
    logic       i_load_start;
    logic       i_key_bit;
    logic       i_key_bit_vld;
    logic [7:0] o_key;
    logic       o_key_valid;
    logic       o_load_busy;
    logic       o_load_err;
    logic       o_lockout;

    int checks;
    int errors;

    key_loader #(.KEY_W(8), .MAX_FAIL(3)) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_load_start  (i_load_start),
        .i_key_bit     (i_key_bit),
        .i_key_bit_vld (i_key_bit_vld),
        .o_key         (o_key),
        .o_key_valid   (o_key_valid),
        .o_load_busy   (o_load_busy),
        .o_load_err    (o_load_err),
        .o_lockout     (o_lockout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start_load();
        i_load_start = 1'b1;
        @(negedge clk);
        i_load_start = 1'b0;
    endtask

    // Shift 8 data bits LSB first then the parity bit; returns just after the parity edge
    task automatic shift_bits(input logic [7:0] d, input logic p, input bit gaps);
        int n;
        for (int i = 0; i < 9; i++) begin
            if (gaps) begin
                n = (i == 3) ? 2 : int'($urandom_range(0, 2));
                repeat (n) begin
                    i_key_bit_vld = 1'b0;
                    i_load_start  = 1'b1;
                    i_key_bit     = 1'b1;
                    @(negedge clk);
                end
            end
            i_load_start  = gaps && (i % 2 == 1);
            i_key_bit     = (i < 8) ? d[i] : p;
            i_key_bit_vld = 1'b1;
            @(negedge clk);
        end
        i_key_bit_vld = 1'b0;
        i_load_start  = 1'b0;
        i_key_bit     = 1'b0;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_load_start = 1'b0; i_key_bit = 1'b0; i_key_bit_vld = 1'b0;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        checks++; if (o_key !== 8'h00) begin errors++; $display("FAIL reset_key: got %h expected 00", o_key); end
        checks++; if (o_key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_key_valid); end
        checks++; if (o_load_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_load_busy); end
        checks++; if (o_load_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", o_load_err); end
        checks++; if (o_lockout !== 1'b0) begin errors++; $display("FAIL reset_lockout: got %b expected 0", o_lockout); end
    endtask

    task automatic test_good_load();
        start_load();
        checks++; if (o_load_busy !== 1'b1) begin errors++; $display("FAIL good_busy_shift: got %b expected 1", o_load_busy); end
        shift_bits(8'hA5, 1'b0, 1'b0);
        checks++; if (o_key_valid !== 1'b0) begin errors++; $display("FAIL good_valid_in_check: got %b expected 0", o_key_valid); end
        checks++; if (o_load_busy !== 1'b1) begin errors++; $display("FAIL good_busy_check: got %b expected 1", o_load_busy); end
        @(negedge clk);
        checks++; if (o_key !== 8'hA5) begin errors++; $display("FAIL good_key: got %h expected a5", o_key); end
        checks++; if (o_key_valid !== 1'b1) begin errors++; $display("FAIL good_valid: got %b expected 1", o_key_valid); end
        checks++; if (o_load_err !== 1'b0) begin errors++; $display("FAIL good_err: got %b expected 0", o_load_err); end
        checks++; if (o_load_busy !== 1'b0) begin errors++; $display("FAIL good_busy_idle: got %b expected 0", o_load_busy); end
        @(negedge clk);
        checks++; if (o_key !== 8'hA5) begin errors++; $display("FAIL good_key_hold: got %h expected a5", o_key); end
    endtask

    task automatic test_bad_parity();
        start_load();
        shift_bits(8'h01, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (o_load_err !== 1'b1) begin errors++; $display("FAIL bad_err_pulse: got %b expected 1", o_load_err); end
        checks++; if (o_key !== 8'h00) begin errors++; $display("FAIL bad_key: got %h expected 00", o_key); end
        checks++; if (o_key_valid !== 1'b0) begin errors++; $display("FAIL bad_valid: got %b expected 0", o_key_valid); end
        checks++; if (o_load_busy !== 1'b0) begin errors++; $display("FAIL bad_idle: got %b expected 0", o_load_busy); end
        @(negedge clk);
        checks++; if (o_load_err !== 1'b0) begin errors++; $display("FAIL bad_err_width: got %b expected 0", o_load_err); end
        checks++; if (o_lockout !== 1'b0) begin errors++; $display("FAIL bad_no_lockout: got %b expected 0", o_lockout); end
    endtask

    task automatic test_lockout();
        logic [7:0] bad_keys [3];
        bad_keys[0] = 8'h01; bad_keys[1] = 8'h07; bad_keys[2] = 8'h80;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            start_load();
            shift_bits(bad_keys[k], 1'b0, 1'b0);
            @(negedge clk);
            checks++; if (o_load_err !== 1'b1) begin errors++; $display("FAIL lock_err%0d: got %b expected 1", k, o_load_err); end
            checks++; if (o_lockout !== (k == 2)) begin errors++; $display("FAIL lock_flag%0d: got %b expected %b", k, o_lockout, (k == 2)); end
            @(negedge clk);
        end
        start_load();
        checks++; if (o_load_busy !== 1'b0) begin errors++; $display("FAIL lock_ignore_start: got %b expected 0", o_load_busy); end
        shift_bits(8'h3C, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checks++; if (o_key !== 8'h00) begin errors++; $display("FAIL lock_key: got %h expected 00", o_key); end
        checks++; if (o_key_valid !== 1'b0) begin errors++; $display("FAIL lock_valid: got %b expected 0", o_key_valid); end
        checks++; if (o_lockout !== 1'b1) begin errors++; $display("FAIL lock_sticky: got %b expected 1", o_lockout); end
        do_reset();
        checks++; if (o_lockout !== 1'b0) begin errors++; $display("FAIL lock_rst_clear: got %b expected 0", o_lockout); end
    endtask

    task automatic test_back_to_back();
        start_load();
        shift_bits(8'hA5, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (o_key !== 8'hA5) begin errors++; $display("FAIL b2b_first: got %h expected a5", o_key); end
        start_load();
        checks++; if (o_key !== 8'h00) begin errors++; $display("FAIL b2b_drop_key: got %h expected 00", o_key); end
        checks++; if (o_key_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop_valid: got %b expected 0", o_key_valid); end
        shift_bits(8'h5A, 1'b0, 1'b0);
        checks++; if (o_key !== 8'h00) begin errors++; $display("FAIL b2b_no_partial: got %h expected 00", o_key); end
        @(negedge clk);
        checks++; if (o_key !== 8'h5A) begin errors++; $display("FAIL b2b_second: got %h expected 5a", o_key); end
        checks++; if (o_key_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_valid: got %b expected 1", o_key_valid); end
    endtask

    task automatic test_gaps();
        start_load();
        shift_bits(8'hC3, 1'b0, 1'b1);
        checks++; if (o_load_busy !== 1'b1) begin errors++; $display("FAIL gap_busy_check: got %b expected 1", o_load_busy); end
        @(negedge clk);
        checks++; if (o_key !== 8'hC3) begin errors++; $display("FAIL gap_key: got %h expected c3", o_key); end
        checks++; if (o_key_valid !== 1'b1) begin errors++; $display("FAIL gap_valid: got %b expected 1", o_key_valid); end
        checks++; if (o_load_err !== 1'b0) begin errors++; $display("FAIL gap_err: got %b expected 0", o_load_err); end
    endtask

    task automatic test_mid_reset();
        start_load();
        for (int i = 0; i < 4; i++) begin
            i_key_bit = 1'b1; i_key_bit_vld = 1'b1;
            @(negedge clk);
        end
        i_key_bit_vld = 1'b0;
        do_reset();
        checks++; if (o_load_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", o_load_busy); end
        checks++; if (o_key !== 8'h00) begin errors++; $display("FAIL midrst_key: got %h expected 00", o_key); end
        checks++; if (o_key_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", o_key_valid); end
        start_load();
        shift_bits(8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (o_key !== 8'hFF) begin errors++; $display("FAIL midrst_reload: got %h expected ff", o_key); end
        checks++; if (o_key_valid !== 1'b1) begin errors++; $display("FAIL midrst_reload_valid: got %b expected 1", o_key_valid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        i_rst = 1'b1; i_load_start = 1'b0; i_key_bit = 1'b0; i_key_bit_vld = 1'b0;
        @(negedge clk);
        test_reset();
        test_good_load();
        test_bad_parity();
        test_lockout();
        test_back_to_back();
        test_gaps();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_key_loader
